mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu.sv | 179 +++++++++++++++++
 tb/tb_mdu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and the FSM state type. The instruction decoder and the
// hazard unit import this package as well, so the encodings have one owner.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6
   } op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Busy down-counter width; comfortably covers both default latencies.
   localparam int CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Operations that occupy the unit for several cycles.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) ||
             (op == OP_DIV)  || (op == OP_DIVU);
   endfunction

   // Any operation that touches HI/LO; the hazard unit stalls on these.
   function automatic logic is_mdu_op(input logic [3:0] op);
      return is_muldiv(op) || (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The full result is computed behaviourally when the op is accepted and
// parked in temp registers; a down-counter models the iterative latency and
// the result is committed to HI/LO on the edge that drops busy.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               busy_nxt;
   logic               start;
   logic               commit;
   logic               mthi_we;
   logic               mtlo_we;

   logic [31:0]        tmp_hi, tmp_lo;
   logic               tmp_skip;

   logic [31:0]        res_hi, res_lo;
   logic               res_skip;

   logic signed [63:0] a_s, b_s, prod_s;
   logic [63:0]        prod_u;

   // Signed divide returning {remainder, quotient}. Works on magnitudes so the
   // 0x80000000 / -1 case wraps to 0x80000000 instead of overflowing; quotient
   // truncates toward zero and the remainder follows the dividend's sign.
   function automatic logic [63:0] sdivmod(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] un, ud, uq, ur, q, r;
      un = n[31] ? (~n + 32'd1) : n;
      ud = d[31] ? (~d + 32'd1) : d;
      if (ud == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = un / ud;
         ur = un % ud;
      end
      q = (n[31] ^ d[31]) ? (~uq + 32'd1) : uq;
      r = n[31] ? (~ur + 32'd1) : ur;
      return {r, q};
   endfunction

   // Unsigned divide returning {remainder, quotient}; zero divisor yields zero.
   function automatic logic [63:0] udivmod(input logic [31:0] n, input logic [31:0] d);
      if (d == 32'd0)
         return 64'd0;
      return {n % d, n / d};
   endfunction

   assign a_s    = {{32{a[31]}}, a};
   assign b_s    = {{32{b[31]}}, b};
   assign prod_s = a_s * b_s;
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Select the full result for the incoming op; b=0 divides are flagged so
   // the commit leaves HI/LO untouched.
   always_comb begin
      res_hi   = 32'd0;
      res_lo   = 32'd0;
      res_skip = 1'b0;
      case (op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            {res_hi, res_lo} = sdivmod(a, b);
            res_skip         = (b == 32'd0);
         end
         OP_DIVU: begin
            {res_hi, res_lo} = udivmod(a, b);
            res_skip         = (b == 32'd0);
         end
         default: ;
      endcase
   end

   // Next-state logic: accept work only in IDLE, count down in BUSY and
   // raise commit on the final busy cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start     = 1'b0;
      commit    = 1'b0;
      mthi_we   = 1'b0;
      mtlo_we   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) begin
               if (is_muldiv(op)) begin
                  start     = 1'b1;
                  state_nxt = ST_BUSY;
                  if ((op == OP_DIV) || (op == OP_DIVU))
                     cnt_nxt = CNT_W'(DIV_CYCLES);
                  else
                     cnt_nxt = CNT_W'(MULT_CYCLES);
               end else if (op == OP_MTHI) begin
                  mthi_we = 1'b1;
               end else if (op == OP_MTLO) begin
                  mtlo_we = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (cnt <= CNT_W'(1)) begin
               commit    = 1'b1;
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      busy_nxt = (state_nxt == ST_BUSY);
   end

   // Control registers: FSM state, latency counter and registered busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
      end
   end

   // Temp registers hold the pending result while the unit is busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmp_hi   <= 32'd0;
         tmp_lo   <= 32'd0;
         tmp_skip <= 1'b0;
      end else if (start) begin
         tmp_hi   <= res_hi;
         tmp_lo   <= res_lo;
         tmp_skip <= res_skip;
      end
   end

   // Architectural HI/LO: written by a completing op or by MTHI/MTLO; reset
   // wins, so an aborted op can never land here.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (commit) begin
         if (!tmp_skip) begin
            hi <= tmp_hi;
            lo <= tmp_lo;
         end
      end else begin
         if (mthi_we)
            hi <= a;
         if (mtlo_we)
            lo <= a;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a table of single operations with hand-computed
// HI/LO and busy length, followed by hand sequences for the multi-cycle
// corners (issue while busy, back-to-back issue, reset mid-divide).
module tb_mdu;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int total;
   int bad;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   localparam int NVEC = 15;
   vec_t v[NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present one op for a single clock; returns at the negedge after the
   // accepting edge with en already dropped.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      en = 1'b1;
      op = o;
      a  = x;
      b  = y;
      @(negedge clk);
      en = 1'b0;
      op = 4'd0;
      a  = 32'd0;
      b  = 32'd0;
   endtask

   // Count negedges with busy high until it falls, bounded.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] exp_hi, exp_lo;
      int          n;

      total = 0;
      bad   = 0;

      v[0]  = '{4'(OP_MULT),  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
      v[1]  = '{4'(OP_MULTU), 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      v[2]  = '{4'(OP_DIV),   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      v[3]  = '{4'(OP_DIVU),  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      v[4]  = '{4'(OP_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      v[5]  = '{4'(OP_DIVU),  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
      v[6]  = '{4'(OP_DIV),   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      v[7]  = '{4'(OP_MULT),  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      v[8]  = '{4'(OP_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      v[9]  = '{4'(OP_MTHI),  32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
      v[10] = '{4'(OP_MTLO),  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};
      v[11] = '{4'(OP_NOP),   32'h55555555, 32'd3,        32'h12345678, 32'hCAFEBABE, 0};
      v[12] = '{4'd9,         32'hAAAAAAAA, 32'd3,        32'h12345678, 32'hCAFEBABE, 0};
      v[13] = '{4'(OP_MULT),  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
      v[14] = '{4'(OP_DIV),   32'hFFFFFFF9, 32'd0,        32'h00000000, 32'h00000001, 10};

      reset = 1'b1;
      en    = 1'b0;
      op    = 4'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      exp_hi = 32'd0;
      exp_lo = 32'd0;
      for (int i = 0; i < NVEC; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         if (v[i].cyc > 0) begin
            chk($sformatf("vec%0d_hold_hi", i), hi, exp_hi);
            chk($sformatf("vec%0d_hold_lo", i), lo, exp_lo);
         end
         wait_idle(n);
         chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(v[i].cyc));
         chk($sformatf("vec%0d_hi", i), hi, v[i].hi);
         chk($sformatf("vec%0d_lo", i), lo, v[i].lo);
         exp_hi = v[i].hi;
         exp_lo = v[i].lo;
      end

      // MTLO issued mid-MULT must be dropped; MULT still takes 5 cycles.
      issue(4'(OP_MULT), 32'd2, 32'd3);
      @(negedge clk);
      issue(4'(OP_MTLO), 32'hDEADBEEF, 32'd0);
      wait_idle(n);
      chk("busy_mtlo_cycles", 32'(n + 2), 32'd5);
      chk("busy_mtlo_hi", hi, 32'd0);
      chk("busy_mtlo_lo", lo, 32'd6);

      // Back-to-back: second MULT presented in the first non-busy cycle.
      issue(4'(OP_MULT), 32'd4, 32'd5);
      wait_idle(n);
      chk("b2b_first_cycles", 32'(n), 32'd5);
      chk("b2b_first_lo", lo, 32'd20);
      issue(4'(OP_MULT), 32'd3, 32'd3);
      chk("b2b_reassert", {31'd0, busy}, 32'd1);
      wait_idle(n);
      chk("b2b_second_cycles", 32'(n), 32'd5);
      chk("b2b_second_lo", lo, 32'd9);
      chk("b2b_second_hi", hi, 32'd0);

      // Reset in the 4th busy cycle of a divide aborts it for good.
      issue(4'(OP_DIV), 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      chk("abort_busy_c4", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      repeat (15) @(negedge clk);
      chk("abort_late_busy", {31'd0, busy}, 32'd0);
      chk("abort_late_hi", hi, 32'd0);
      chk("abort_late_lo", lo, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
